// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - frame-buffer memory command and read-return bus
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) ();
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [DATA_W-1:0] mem_cmd_wdata;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    output mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
    input  mem_cmd_ready, mem_rd_valid, mem_rd_data
  );

  modport slave (
    input  mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
    output mem_cmd_ready, mem_rd_valid, mem_rd_data
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - display line fetch / host write arbiter for one frame-buffer port
module vga_fb_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 11,
  parameter int CHUNK  = 16
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LEN_W-1:0]  line_len,
  output logic              line_busy,
  output logic              line_done,
  output logic              line_overrun,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  vga_fb_arbiter_if.master  mem
);

  localparam int CW = $clog2(CHUNK + 1);

  typedef enum logic [1:0] {IDLE, DISP, HOST} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  ret_cnt;
  logic [CW-1:0]     chunk_cnt;

  logic line_accept;
  logic reads_left;
  logic last_issue;
  logic chunk_hit;
  logic slot_free;
  logic load_rd;
  logic load_wr;
  logic chunk_clr;

  assign line_accept = line_req && !line_busy;
  assign reads_left  = line_busy && (issue_cnt != len_r);
  assign last_issue  = (issue_cnt + LEN_W'(1)) == len_r;
  assign chunk_hit   = (chunk_cnt + CW'(1)) == CW'(CHUNK);
  assign slot_free   = !mem.mem_cmd_valid || mem.mem_cmd_ready;

  always_ff @(posedge sys_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Reads always win a free slot; a host write only gets in from IDLE or after CHUNK reads.
  always_comb begin
    state_nxt = state;
    load_rd   = 1'b0;
    load_wr   = 1'b0;
    chunk_clr = 1'b0;
    wr_ready  = 1'b0;
    if (!rst && slot_free) begin
      case (state)
        IDLE, DISP: begin
          if (reads_left) begin
            load_rd = 1'b1;
            if (last_issue) begin
              state_nxt = IDLE;
              chunk_clr = chunk_hit;
            end else if (chunk_hit && wr_valid) begin
              state_nxt = HOST;
            end else begin
              state_nxt = DISP;
              chunk_clr = chunk_hit;
            end
          end else if (state == IDLE && wr_valid && !line_accept) begin
            wr_ready  = 1'b1;
            load_wr   = 1'b1;
            chunk_clr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
        HOST: begin
          wr_ready  = wr_valid;
          load_wr   = wr_valid;
          chunk_clr = 1'b1;
          state_nxt = reads_left ? DISP : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      base_r       <= '0;
      len_r        <= '0;
      issue_cnt    <= '0;
      chunk_cnt    <= '0;
      line_overrun <= 1'b0;
    end else begin
      line_overrun <= line_req && line_busy;
      if (line_accept) begin
        base_r    <= line_addr;
        len_r     <= line_len;
        issue_cnt <= '0;
        chunk_cnt <= '0;
      end else if (load_rd) begin
        issue_cnt <= issue_cnt + LEN_W'(1);
        chunk_cnt <= chunk_clr ? '0 : chunk_cnt + CW'(1);
      end else if (chunk_clr) begin
        chunk_cnt <= '0;
      end
    end
  end

  // Command register: reloads whenever the current command is gone or leaving this cycle.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      mem.mem_cmd_valid <= 1'b0;
      mem.mem_cmd_we    <= 1'b0;
      mem.mem_cmd_addr  <= '0;
      mem.mem_cmd_wdata <= '0;
    end else if (slot_free) begin
      mem.mem_cmd_valid <= load_rd || load_wr;
      if (load_rd) begin
        mem.mem_cmd_we    <= 1'b0;
        mem.mem_cmd_addr  <= base_r + ADDR_W'(issue_cnt);
        mem.mem_cmd_wdata <= '0;
      end else if (load_wr) begin
        mem.mem_cmd_we    <= 1'b1;
        mem.mem_cmd_addr  <= wr_addr;
        mem.mem_cmd_wdata <= wr_data;
      end
    end
  end

  // Return path; busy drops one cycle after the final word so line_done lines up with it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      line_busy  <= 1'b0;
      line_done  <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      ret_cnt    <= '0;
    end else begin
      line_done  <= 1'b0;
      disp_valid <= 1'b0;
      if (line_accept) begin
        ret_cnt <= '0;
        if (line_len == '0) line_done <= 1'b1;
        else                line_busy <= 1'b1;
      end else if (line_busy) begin
        if (mem.mem_rd_valid && ret_cnt != len_r) begin
          disp_valid <= 1'b1;
          disp_data  <= mem.mem_rd_data;
          ret_cnt    <= ret_cnt + LEN_W'(1);
          if ((ret_cnt + LEN_W'(1)) == len_r) line_done <= 1'b1;
        end else if (ret_cnt == len_r) begin
          line_busy <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        line_req;
  logic [19:0] line_addr;
  logic [10:0] line_len;
  logic        line_busy, line_done, line_overrun, disp_valid;
  logic [15:0] disp_data;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;

  vga_fb_arbiter_if #(.ADDR_W(20), .DATA_W(16)) mem ();

  vga_fb_arbiter #(.ADDR_W(20), .DATA_W(16), .LEN_W(11), .CHUNK(4)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .line_req(line_req), .line_addr(line_addr), .line_len(line_len),
    .line_busy(line_busy), .line_done(line_done), .line_overrun(line_overrun),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem(mem)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_pulses = 0;
  int done_cnt = 0;
  logic [36:0] cmd_log[$];
  int          cmd_cyc[$];
  logic [15:0] disp_log[$];

  logic        acc_v = 1'b0;
  logic [15:0] acc_d = '0;
  logic [2:0]  p_v = '0;
  logic [15:0] p_d[3];
  logic        prev_stall = 1'b0;
  logic [37:0] prev_cmd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: in-order reads, fixed pipeline latency, data = addr ^ 5A5A.
  always @(posedge sys_clk) begin
    cyc++;
    #1;
    mem.mem_rd_valid = p_v[2];
    mem.mem_rd_data  = p_d[2];
    p_v[2] = p_v[1]; p_d[2] = p_d[1];
    p_v[1] = p_v[0]; p_d[1] = p_d[0];
    p_v[0] = acc_v;  p_d[0] = acc_d;
  end

  always @(negedge sys_clk) begin
    if (prev_stall)
      check("cmd_hold", {mem.mem_cmd_valid, mem.mem_cmd_we, mem.mem_cmd_addr, mem.mem_cmd_wdata}, prev_cmd);
    if (mem.mem_cmd_valid && mem.mem_cmd_ready) begin
      cmd_log.push_back({mem.mem_cmd_we, mem.mem_cmd_addr, mem.mem_cmd_wdata});
      cmd_cyc.push_back(cyc);
    end
    if (disp_valid) disp_log.push_back(disp_data);
    if (wr_ready && wr_valid) wr_pulses++;
    if (line_done) done_cnt++;
    acc_v = mem.mem_cmd_valid && mem.mem_cmd_ready && !mem.mem_cmd_we;
    acc_d = mem.mem_cmd_addr[15:0] ^ 16'h5A5A;
    prev_stall = mem.mem_cmd_valid && !mem.mem_cmd_ready && !rst;
    prev_cmd = {mem.mem_cmd_valid, mem.mem_cmd_we, mem.mem_cmd_addr, mem.mem_cmd_wdata};
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk); #1;
  endtask

  task automatic tick();
    @(negedge sys_clk); #1;
  endtask

  task automatic clear_logs();
    cmd_log.delete(); cmd_cyc.delete(); disp_log.delete();
    wr_pulses = 0; done_cnt = 0;
  endtask

  task automatic start_line(input logic [19:0] a, input logic [10:0] l);
    step();
    line_addr = a; line_len = l; line_req = 1'b1;
    step();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (line_done) got = 1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  initial begin
    logic [36:0] exp_cmd;
    int r;
    rst = 1'b1; line_req = 1'b0; line_addr = '0; line_len = '0;
    wr_valid = 1'b1; wr_addr = 20'h01234; wr_data = 16'hBEEF;
    mem.mem_cmd_ready = 1'b1;
    repeat (3) step();
    tick();
    check("rst_busy", line_busy, 0);
    check("rst_done", line_done, 0);
    check("rst_overrun", line_overrun, 0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data", disp_data, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_cmd", {mem.mem_cmd_valid, mem.mem_cmd_we, mem.mem_cmd_addr, mem.mem_cmd_wdata}, 0);
    step();
    rst = 1'b0; wr_valid = 1'b0;
    repeat (2) step();

    // single line, ready always high
    clear_logs();
    start_line(20'h00100, 11'd8);
    tick();
    check("t1_busy", line_busy, 1);
    check("t1_lat1_no_cmd", mem.mem_cmd_valid, 0);
    tick();
    check("t1_first_cmd", {mem.mem_cmd_valid, mem.mem_cmd_we, mem.mem_cmd_addr}, {1'b1, 1'b0, 20'h00100});
    wait_done("t1_done", 40);
    check("t1_done_with_last", disp_valid, 1);
    check("t1_ndisp", disp_log.size(), 8);
    check("t1_ncmd", cmd_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t1_addr", cmd_log[i], {1'b0, 20'h00100 + 20'(i), 16'h0});
      check("t1_data", disp_log[i], (16'h0100 + 16'(i)) ^ 16'h5A5A);
    end
    check("t1_consecutive", cmd_cyc[7] - cmd_cyc[0], 7);
    tick();
    check("t1_busy_clr", line_busy, 0);
    repeat (3) step();

    // contention: CHUNK=4, host write held until two grants
    clear_logs();
    step();
    wr_addr = 20'h03000; wr_data = 16'hF800; wr_valid = 1'b1;
    line_addr = 20'h00200; line_len = 11'd10; line_req = 1'b1;
    tick();
    check("t2_line_wins", wr_ready, 0);
    step();
    line_req = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (wr_pulses >= 2) wr_valid = 1'b0;
      tick();
      if (line_done) break;
      step();
    end
    wr_valid = 1'b0;
    check("t2_done_seen", done_cnt, 1);
    check("t2_wr_pulses", wr_pulses, 2);
    check("t2_ncmd", cmd_log.size(), 12);
    check("t2_ndisp", disp_log.size(), 10);
    r = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 4 || i == 9) exp_cmd = {1'b1, 20'h03000, 16'hF800};
      else begin
        exp_cmd = {1'b0, 20'h00200 + 20'(r), 16'h0};
        r++;
      end
      check("t2_order", cmd_log[i], exp_cmd);
    end
    repeat (3) step();

    // backpressure mid-burst
    clear_logs();
    start_line(20'h00400, 11'd12);
    repeat (3) step();
    mem.mem_cmd_ready = 1'b0;
    repeat (5) step();
    mem.mem_cmd_ready = 1'b1;
    wait_done("t3_done", 60);
    check("t3_ncmd", cmd_log.size(), 12);
    check("t3_ndisp", disp_log.size(), 12);
    for (int i = 0; i < 12; i++)
      check("t3_addr", cmd_log[i], {1'b0, 20'h00400 + 20'(i), 16'h0});
    check("t3_last_data", disp_log[11], 16'h040B ^ 16'h5A5A);
    repeat (3) step();

    // overrun while busy
    clear_logs();
    start_line(20'h00500, 11'd6);
    step();
    line_addr = 20'h00900; line_len = 11'd3; line_req = 1'b1;
    step();
    line_req = 1'b0;
    tick();
    check("t4_overrun", line_overrun, 1);
    check("t4_still_busy", line_busy, 1);
    wait_done("t4_done", 40);
    check("t4_ncmd", cmd_log.size(), 6);
    check("t4_first", cmd_log[0], {1'b0, 20'h00500, 16'h0});
    check("t4_last", cmd_log[5], {1'b0, 20'h00505, 16'h0});
    check("t4_ndisp", disp_log.size(), 6);
    tick();
    check("t4_overrun_pulse", line_overrun, 0);
    repeat (3) step();

    // zero-length line
    clear_logs();
    start_line(20'h00700, 11'd0);
    tick();
    check("t4z_done", line_done, 1);
    check("t4z_busy", line_busy, 0);
    repeat (4) tick();
    check("t4z_no_cmd", cmd_log.size(), 0);
    check("t4z_one_done", done_cnt, 1);

    // address wrap
    clear_logs();
    start_line(20'hFFFFE, 11'd4);
    wait_done("t5_done", 40);
    check("t5_a0", cmd_log[0], {1'b0, 20'hFFFFE, 16'h0});
    check("t5_a1", cmd_log[1], {1'b0, 20'hFFFFF, 16'h0});
    check("t5_a2", cmd_log[2], {1'b0, 20'h00000, 16'h0});
    check("t5_a3", cmd_log[3], {1'b0, 20'h00001, 16'h0});
    check("t5_d2", disp_log[2], 16'h5A5A);
    repeat (3) step();

    // reset mid-line
    clear_logs();
    start_line(20'h00800, 11'd8);
    for (int i = 0; i < 20 && cmd_log.size() < 3; i++) tick();
    check("t6_three_issued", cmd_log.size(), 3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick();
    check("t6_busy", line_busy, 0);
    check("t6_disp_valid", disp_valid, 0);
    check("t6_done", line_done, 0);
    check("t6_cmd", {mem.mem_cmd_valid, mem.mem_cmd_we, mem.mem_cmd_addr, mem.mem_cmd_wdata}, 0);
    clear_logs();
    repeat (8) tick();
    check("t6_late_dropped", disp_log.size(), 0);
    check("t6_no_done", done_cnt, 0);
    clear_logs();
    start_line(20'h00A00, 11'd4);
    wait_done("t6_new_done", 40);
    check("t6_new_ncmd", cmd_log.size(), 4);
    check("t6_new_first", cmd_log[0], {1'b0, 20'h00A00, 16'h0});
    check("t6_new_last", cmd_log[3], {1'b0, 20'h00A03, 16'h0});
    check("t6_new_ndisp", disp_log.size(), 4);
    check("t6_new_d0", disp_log[0], 16'h0A00 ^ 16'h5A5A);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer memory between two requesters:
  - the display line fetcher, which reads one scan line ahead of the VGA driver's data requests;
  - a host pixel-write port.
- Display bursts have priority.
- The host is guaranteed one write slot after every CHUNK display reads, so neither side starves.
- Sits between the pixel source logic and the memory controller, upstream of the VGA driver's data input.

Parameters:
ADDR_W, 20, memory word-address width
DATA_W, 16, pixel word width (RGB565)
LEN_W, 11, width of line length field (max 2047 words)
CHUNK, 16, display read commands issued before a pending host write must be serviced (>=1)

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous active-high reset
line_req  in  1  one-cycle pulse: fetch a line
line_addr  in  ADDR_W  line base word address, sampled with line_req
line_len  in  LEN_W  words in line, sampled with line_req
line_busy  out  1  display fetch in progress
line_done  out  1  one-cycle pulse after last word of line delivered
line_overrun  out  1  one-cycle pulse: line_req arrived while line_busy
disp_valid  out  1  display read word valid
disp_data  out  DATA_W  display read word
wr_valid  in  1  host write request
wr_ready  out  1  host write accepted this cycle (valid&ready)
wr_addr  in  ADDR_W  host write address
wr_data  in  DATA_W  host write data
mem_cmd_valid  out  1  memory command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_we  out  1  1=write, 0=read
mem_cmd_addr  out  ADDR_W  command address
mem_cmd_wdata  out  DATA_W  write data
mem_rd_valid  in  1  read data return, in order, any latency >=1, no backpressure
mem_rd_data  in  DATA_W  read data

Behaviour:
- Reset (sync, rst=1 at sys_clk edge) clears everything:
  - all outputs 0 (mem_cmd_addr/wdata/disp_data 0);
  - state=IDLE; issue, return and chunk counters =0.
- Reset mid-burst abandons the line; no line_done.
- mem_rd_valid arriving while !line_busy is dropped (disp_valid stays 0).
- Command register (cmd_full): mem_cmd_* are registered outputs.
  - mem_cmd_valid stays high with stable fields until mem_cmd_ready.
  - Register may reload in the same cycle it is consumed: a "free" slot = !cmd_full | mem_cmd_ready.
- Line accept:
  - line_req && !line_busy: latch base/len, clear issue_cnt, ret_cnt, chunk_cnt; line_busy=1 next cycle.
  - line_req && line_busy: ignored, line_overrun=1 next cycle.
- line_len=0: no commands; line_busy stays 0; line_done pulses 1 cycle after line_req.
- FSM states (evaluated each free slot):
  - IDLE:
    - line_busy with issues remaining -> load read cmd, go DISP.
    - else wr_valid -> wr_ready=1, load write cmd, stay IDLE.
    - A line_req in the same cycle as wr_valid in IDLE wins: wr_ready=0 that cycle.
  - DISP: load read at line_base+issue_cnt (mod 2^ADDR_W); issue_cnt++, chunk_cnt++.
    - If chunk_cnt reaches CHUNK and wr_valid -> HOST.
    - If issue_cnt reaches line_len -> IDLE.
  - HOST: wr_ready=1 combinationally for exactly one cycle when slot free; load write cmd; clear chunk_cnt.
    - Next state DISP if reads remain, else IDLE.
    - If wr_valid dropped, clear chunk_cnt, back to DISP without a write.
  - chunk_cnt also clears whenever a write is issued from IDLE and when CHUNK reached with no host pending.
- wr_ready is never high when no write is loaded that cycle.
- Read return path:
  - mem_rd_valid while line_busy && ret_cnt<line_len -> disp_valid=1 next cycle with disp_data=mem_rd_data; ret_cnt++.
  - When ret_cnt reaches line_len: line_done=1 (same cycle as last disp_valid), line_busy=0 the following cycle.
- Latency: line_req -> first mem_cmd_valid = 2 cycles. mem_rd_valid -> disp_valid = 1 cycle.
- Address wrap: base+index wraps at 2^ADDR_W, no error.

Test Plan:
- Single line, mem_cmd_ready=1, 3-cycle read latency, line_addr=0x00100, len=8 -> reads to 0x00100..0x00107 on consecutive cycles; 8 disp_valid words in order; line_done with 8th word.
- Contention with CHUNK=4, len=10, wr_valid held (addr 0x3000, data 0xF800) -> command order R R R R W R R R R W R R. wr_ready pulses exactly twice, each coincident with write load.
- Backpressure: mem_cmd_ready low 5 cycles mid-burst -> mem_cmd_* held stable; no skipped or duplicated addresses.
- Overrun and zero-length:
  - line_req during busy -> line_overrun pulse; current line unaffected.
  - len=0 -> no commands; line_done 1 cycle later.
- Wrap: line_addr=0xFFFFE, len=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Reset mid-operation: rst after 3 of 8 reads issued -> all outputs 0 next cycle. Late mem_rd_valid produces no disp_valid; new line_req works normally.
